// File: rtl/axi_slave_ram_if.sv
// AXI4 bus bundle between a core master port and the RAM responder.
// Only the five channels are carried; clock and reset stay plain ports.
interface axi_slave_ram_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  // Write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  // Write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 memory responder: one read or write burst at a time, INCR 4-byte beats,
// backed by a word-addressed synchronous RAM (ram_array) that wraps at its end.
module axi_slave_ram #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_MEM_WORDS      = 2048
) (
  input  logic           clk,
  input  logic           rst,
  axi_slave_ram_if.slave s_axi,
  output logic [1:0]     dbg_state
);
  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam int NB    = C_AXI_DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t state, state_next;

  logic [C_AXI_DATA_WIDTH-1:0] ram_array [C_MEM_WORDS];

  logic                        prio_w;
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                  len_q;
  logic [7:0]                  beat_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        err_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                        rvalid_q;
  logic                        rlast_q;

  logic grant_w, grant_r;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs, r_load;
  logic unused_bits;

  // Every channel transfers on the rising edge where its valid and ready are
  // both high; a raised valid keeps its payload stable until that edge.
  assign grant_w = s_axi.awvalid & (~s_axi.arvalid | prio_w);
  assign grant_r = s_axi.arvalid & (~s_axi.awvalid | ~prio_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axi.awready = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    aw_hs         = 1'b0;
    ar_hs         = 1'b0;
    w_hs          = 1'b0;
    b_hs          = 1'b0;
    r_hs          = 1'b0;
    r_load        = 1'b0;
    unique case (state)
      IDLE: begin
        s_axi.awready = grant_w;
        s_axi.arready = grant_r;
        aw_hs         = grant_w;
        ar_hs         = grant_r;
        if (grant_w)      state_next = WDATA;
        else if (grant_r) state_next = RDATA;
      end
      WDATA: begin
        s_axi.wready = 1'b1;
        w_hs         = s_axi.wvalid;
        // The beat counter, not WLAST, decides where the burst ends.
        if (s_axi.wvalid && (beat_q == len_q)) state_next = WRESP;
      end
      WRESP: begin
        s_axi.bvalid = 1'b1;
        b_hs         = s_axi.bready;
        if (s_axi.bready) state_next = IDLE;
      end
      RDATA: begin
        r_hs = rvalid_q & s_axi.rready;
        // Fill the output register on entry and refill it on every accepted
        // non-final beat, so RREADY held high streams one beat per cycle.
        r_load = ~rvalid_q | (r_hs & ~rlast_q);
        if (r_hs && rlast_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_w   <= 1'b1;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q   <= s_axi.awid;
        len_q  <= s_axi.awlen;
        idx_q  <= s_axi.awaddr[IDX_W+1:2];
        beat_q <= '0;
        err_q  <= 1'b0;
        prio_w <= 1'b0;
      end else if (ar_hs) begin
        id_q   <= s_axi.arid;
        len_q  <= s_axi.arlen;
        idx_q  <= s_axi.araddr[IDX_W+1:2];
        beat_q <= '0;
        prio_w <= 1'b1;
      end

      if (w_hs) begin
        idx_q  <= idx_q + IDX_ONE;
        beat_q <= beat_q + 8'd1;
        // WLAST must be high on the final beat and only there.
        if (beat_q == len_q) err_q <= err_q | ~s_axi.wlast;
        else                 err_q <= err_q | s_axi.wlast;
      end

      if (b_hs) err_q <= 1'b0;

      if (r_load) begin
        rdata_q  <= ram_array[idx_q];
        idx_q    <= idx_q + IDX_ONE;
        beat_q   <= beat_q + 8'd1;
        rvalid_q <= 1'b1;
        rlast_q  <= (beat_q == len_q);
      end else if (r_hs && rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; a burst cut short leaves its beats behind.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi.wstrb[b]) ram_array[idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.bid    = id_q;
  assign s_axi.bresp  = err_q ? 2'b10 : 2'b00;
  assign s_axi.rid    = id_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = 2'b00;
  assign s_axi.rlast  = rlast_q;
  assign s_axi.rvalid = rvalid_q;
  assign dbg_state    = state;

  // Size, burst type and address bits outside the RAM window carry no meaning here.
  assign unused_bits = ^{s_axi.awaddr[C_OFFSET_WIDTH-1:IDX_W+2], s_axi.awaddr[1:0],
                         s_axi.araddr[C_OFFSET_WIDTH-1:IDX_W+2], s_axi.araddr[1:0],
                         s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst};
endmodule
